// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor: difference and borrow-out for a single bit position.
module sub_bit_cell (
    input  logic a,
    input  logic b,
    input  logic br,
    output logic d,
    output logic br_next
);

    assign d       = a ^ b ^ br;
    assign br_next = (~a & b) | (~(a ^ b) & br);

endmodule

// File: rtl/serial_sub.sv
// Bit-serial subtractor, LSB first, one bit per clock through a single sub_bit_cell.
// Define SERIAL_SUB_OVF_EN to build the two's-complement overflow flag; otherwise ovf_out is 0.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             borrow_in,
    output logic             busy_out,
    output logic             done_out,
    output logic [WIDTH-1:0] diff_out,
    output logic             borrow_out,
    output logic             ovf_out,
    output logic [1:0]       state_dbg_out
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    // Handshake: start_in is sampled at a rising edge only in IDLE or DONE; that edge
    // latches the operands and raises busy_out. done_out pulses for one cycle with the result.
    state_e           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             br;
    logic [CW-1:0]    cnt;
    logic             d;
    logic             br_next;
    logic             load;
    logic             finish;

    assign load          = start_in && (state != RUN);
    assign finish        = (state == RUN) && (cnt == LAST);
    assign state_dbg_out = state;

    sub_bit_cell u_cell (
        .a       (a_sh[0]),
        .b       (b_sh[0]),
        .br      (br),
        .d       (d),
        .br_next (br_next)
    );

    // Difference bits refill a_sh from the top as minuend bits are consumed.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            br         <= 1'b0;
            cnt        <= '0;
            busy_out   <= 1'b0;
            done_out   <= 1'b0;
            diff_out   <= '0;
            borrow_out <= 1'b0;
        end else if (state == RUN) begin
            a_sh <= {d, a_sh[WIDTH-1:1]};
            b_sh <= {1'b0, b_sh[WIDTH-1:1]};
            br   <= br_next;
            cnt  <= cnt + CW'(1);
            if (finish) begin
                state      <= DONE;
                busy_out   <= 1'b0;
                done_out   <= 1'b1;
                diff_out   <= {d, a_sh[WIDTH-1:1]};
                borrow_out <= br_next;
            end
        end else begin
            done_out <= 1'b0;
            if (load) begin
                state    <= RUN;
                a_sh     <= a_in;
                b_sh     <= b_in;
                br       <= borrow_in;
                cnt      <= '0;
                busy_out <= 1'b1;
            end else begin
                state <= IDLE;
            end
        end
    end

`ifdef SERIAL_SUB_OVF_EN
    logic a_msb;
    logic b_msb;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf_out <= 1'b0;
        end else begin
            if (load) begin
                a_msb <= a_in[WIDTH-1];
                b_msb <= b_in[WIDTH-1];
            end
            if (finish) begin
                ovf_out <= (a_msb != b_msb) && (d != a_msb);
            end
        end
    end
`else
    assign ovf_out = 1'b0;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// Directed testbench for serial_sub at WIDTH=8.
module tb_serial_sub;
    import serial_sub_pkg::*;

    localparam int W = 8;
`ifdef SERIAL_SUB_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    logic [1:0]   state_dbg;

    int           vectors;
    int           miscompares;
    logic [W-1:0] prev_diff;

    serial_sub #(.WIDTH(W)) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .a_in          (a),
        .b_in          (b),
        .borrow_in     (bin),
        .busy_out      (busy),
        .done_out      (done),
        .diff_out      (diff),
        .borrow_out    (bout),
        .ovf_out       (ovf),
        .state_dbg_out (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // drivers
    task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
        a = av; b = bv; bin = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = ~av; b = ~bv; bin = ~bi;   // operands must already be latched
        vectors++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            $display("FAIL accept: busy=%b done=%b, required busy=1 done=0", busy, done);
            miscompares++;
        end
    endtask

    // Runs the WIDTH RUN edges; optionally re-pulses start at RUN edge inj with a=0xFF.
    task automatic finish_op(input string name, input logic [W-1:0] ed, input logic eb,
                             input logic eo, input int inj);
        for (int i = 1; i <= W; i++) begin
            if (i == inj) begin start = 1'b1; a = 8'hFF; end
            @(posedge clk); #1;
            start = 1'b0;
            if (i < W) begin
                vectors++;
                if (done !== 1'b0 || busy !== 1'b1 || diff !== prev_diff) begin
                    $display("FAIL %s edge %0d: done=%b busy=%b diff=%h, required 0 1 %h",
                             name, i, done, busy, diff, prev_diff);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0 || diff !== ed || bout !== eb || ovf !== eo) begin
            $display("FAIL %s result: done=%b busy=%b diff=%h borrow=%b ovf=%b, required 1 0 %h %b %b",
                     name, done, busy, diff, bout, ovf, ed, eb, eo);
            miscompares++;
        end
        prev_diff = ed;
    endtask

    task automatic check_idle_after(input string name, input logic [W-1:0] ed);
        @(posedge clk); #1;
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== ed) begin
            $display("FAIL %s post: done=%b busy=%b diff=%h, required 0 0 %h", name, done, busy, diff, ed);
            miscompares++;
        end
    endtask

    // tests
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0
            || state_dbg !== IDLE) begin
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b ovf=%b state=%0d, required all 0",
                     busy, done, diff, bout, ovf, state_dbg);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
    endtask

    task automatic test_basic();
        accept(8'h5A, 8'h3C, 1'b0);
        finish_op("basic", 8'h1E, 1'b0, 1'b0, 0);
        check_idle_after("basic", 8'h1E);
    endtask

    task automatic test_borrow();
        accept(8'h00, 8'h01, 1'b0);
        finish_op("underflow", 8'hFF, 1'b1, 1'b0, 0);
        check_idle_after("underflow", 8'hFF);
        accept(8'h10, 8'h0F, 1'b1);
        finish_op("borrow_in", 8'h00, 1'b0, 1'b0, 0);
        check_idle_after("borrow_in", 8'h00);
    endtask

    task automatic test_ovf();
        accept(8'h80, 8'h01, 1'b0);
        finish_op("ovf_neg", 8'h7F, 1'b0, OVF_ON, 0);
        check_idle_after("ovf_neg", 8'h7F);
        accept(8'h7F, 8'hFF, 1'b0);
        finish_op("ovf_pos", 8'h80, 1'b1, OVF_ON, 0);
        check_idle_after("ovf_pos", 8'h80);
    endtask

    task automatic test_ignore_start();
        accept(8'h05, 8'h03, 1'b0);
        finish_op("ignore_start", 8'h02, 1'b0, 1'b0, 3);
        for (int i = 0; i < 10; i++) check_idle_after("ignore_start", 8'h02);
    endtask

    task automatic test_reset_abort();
        accept(8'h5A, 8'h3C, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || bout !== 1'b0 || ovf !== 1'b0) begin
            $display("FAIL reset_abort: busy=%b done=%b diff=%h borrow=%b ovf=%b, required all 0",
                     busy, done, diff, bout, ovf);
            miscompares++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        prev_diff = '0;
        for (int i = 0; i < 12; i++) check_idle_after("no_done_after_abort", 8'h00);
        // first start after a fresh release
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        accept(8'hC3, 8'h41, 1'b1);
        finish_op("after_reset", 8'h81, 1'b0, 1'b0, 0);
        check_idle_after("after_reset", 8'h81);
    endtask

    task automatic test_back_to_back();
        accept(8'h33, 8'h44, 1'b0);
        finish_op("b2b_first", 8'hEF, 1'b1, 1'b0, 0);
        accept(8'hA0, 8'h21, 1'b0);
        finish_op("b2b_second", 8'h7F, 1'b0, OVF_ON, 0);
        check_idle_after("b2b_second", 8'h7F);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        prev_diff = '0;
        test_reset();
        test_basic();
        test_borrow();
        test_ovf();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
